// File: rtl/aes_arbiter.sv
// aes_arbiter: shares one AES-128 core between two requesters.
// Round-robin grant, operand latch, core reset sequencing (IDLE -> LAUNCH -> RUN -> RESP)
// and a valid/ready response channel tagged with the requester id.
// Optional feature macro: AES_ARB_TIMEOUT_EN adds a RUN-cycle watchdog that aborts a job
// after TIMEOUT cycles and reports it with rsp_err = 1.
module aes_arbiter #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_mode,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [WIDTH-1:0] req1_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             core_reset,
  output logic             core_mode,
  output logic [WIDTH-1:0] core_data_in,
  output logic [WIDTH-1:0] core_key_in,
  input  logic [WIDTH-1:0] core_data_out,
  input  logic             core_done,
  output logic             busy,
  output logic [15:0]      job_count
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StResp} state_e;

  if (TIMEOUT < 64 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("aes_arbiter: TIMEOUT must lie in 64..65535");
  end

  state_e           state_q;
  logic             last_grant_q;
  logic             id_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic             core_reset_q;
  logic [15:0]      job_count_q;

  logic             grant_valid;
  logic             grant_id;
  logic             accept_open;

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);
  logic [15:0] run_cnt_q;
  logic        rsp_err_q;
`endif

  // Round-robin pick: a lone valid requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Never report acceptance in a cycle whose state update is overridden by reset.
  assign accept_open = (state_q == StIdle) && !reset;
  assign req0_ready  = accept_open && grant_valid && !grant_id;
  assign req1_ready  = accept_open && grant_valid && grant_id;

  // Job sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      mode_q       <= 1'b0;
      data_q       <= '0;
      key_q        <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_reset_q <= 1'b1;
      job_count_q  <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      run_cnt_q    <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            mode_q       <= grant_id ? req1_mode : req0_mode;
            data_q       <= grant_id ? req1_data : req0_data;
            key_q        <= grant_id ? req1_key  : req0_key;
            busy_q       <= 1'b1;
            state_q      <= StLaunch;
          end
        end
        StLaunch: begin
          // Core still held in reset this cycle so it samples the fresh key.
          core_reset_q <= 1'b0;
          state_q      <= StRun;
`ifdef AES_ARB_TIMEOUT_EN
          run_cnt_q    <= '0;
`endif
        end
        StRun: begin
          if (core_done) begin
            rsp_data_q  <= core_data_out;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
`ifdef AES_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (run_cnt_q == TimeoutCnt) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            run_cnt_q   <= run_cnt_q + 16'd1;
          end
`endif
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            job_count_q  <= job_count_q + 16'd1;
            busy_q       <= 1'b0;
            core_reset_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = id_q;
  assign rsp_data     = rsp_data_q;
  assign core_reset   = core_reset_q;
  assign core_mode    = mode_q;
  assign core_data_in = data_q;
  assign core_key_in  = key_q;
  assign busy         = busy_q;
  assign job_count    = job_count_q;

`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_arbiter.sv
// Self-checking bench for aes_arbiter: FIPS-197 lookup core model, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_aes_arbiter;
  localparam int unsigned W   = 128;
  localparam int unsigned TO  = 64;
  localparam int          LAT = 16;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct { bit mode; logic [127:0] data; logic [127:0] key; } job_t;
  typedef struct { bit id; logic [127:0] data; bit err; } rsp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, req0_mode;
  logic [W-1:0] req0_data, req0_key;
  logic         req1_valid, req1_ready, req1_mode;
  logic [W-1:0] req1_data, req1_key;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         core_reset, core_mode;
  logic [W-1:0] core_data_in, core_key_in;
  logic [W-1:0] core_data_out = '0;
  logic         core_done = 1'b0;
  logic         busy;
  logic [15:0]  job_count;

  aes_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_reset(core_reset), .core_mode(core_mode), .core_data_in(core_data_in),
    .core_key_in(core_key_in), .core_data_out(core_data_out), .core_done(core_done),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Known FIPS-197 answers; any other job maps to a distinctive synthetic value.
  function automatic logic [127:0] gold(input bit mode, input logic [127:0] d,
                                        input logic [127:0] k);
    if (!mode && k == K1 && d == P1) return C1;
    if (!mode && k == K2 && d == P2) return C2;
    if (mode && k == K1 && d == C1) return P1;
    if (mode && k == K2 && d == C2) return P2;
    return d ^ k ^ {128{mode}};
  endfunction

  // Core model: done rises LAT cycles after reset release and holds until the next reset.
  bit core_stuck = 1'b0;
  int core_cnt   = 0;
  always @(posedge clk) begin
    if (core_reset === 1'b1) begin
      core_cnt      <= 0;
      core_done     <= 1'b0;
      core_data_out <= '0;
    end else if (!core_stuck) begin
      if (core_cnt == LAT - 1) begin
        core_done     <= 1'b1;
        core_data_out <= gold(core_mode, core_data_in, core_key_in);
      end
      if (core_cnt < LAT) core_cnt <= core_cnt + 1;
    end
  end

  // Requester drivers: hold valid and operands until a handshake is seen.
  job_t q0[$];
  job_t q1[$];
  bit   hs0, hs1;
  always @(posedge clk) begin
    #1;
    if (hs0 && q0.size() > 0) q0.delete(0);
    if (hs1 && q1.size() > 0) q1.delete(0);
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (q0.size() > 0) begin
      req0_mode = q0[0].mode; req0_data = q0[0].data; req0_key = q0[0].key;
    end
    if (q1.size() > 0) begin
      req1_mode = q1[0].mode; req1_data = q1[0].data; req1_key = q1[0].key;
    end
  end

  // Reference model: a job is a record stamped with its accept cycle; timing follows from it.
  bit           started = 1'b0;
  longint       cyc = 0;
  bit           m_active = 1'b0, m_pend = 1'b0, m_last = 1'b1;
  bit           m_mode = 1'b0, m_id = 1'b0, m_err = 1'b0;
  logic [127:0] m_data = '0, m_key = '0, m_rdata = '0;
  logic [15:0]  m_count = '0;
  longint       m_t_acc = 0;
  rsp_t         rsp_log[$];
  bit           grant_log[$];
  int           viol = 0;

  always @(negedge clk) begin
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (started) begin
      bit   ex0, ex1, g;
      rsp_t r;
      ex0 = !m_active && !reset && req0_valid && (!req1_valid || m_last);
      ex1 = !m_active && !reset && req1_valid && (!req0_valid || !m_last);
      check("busy", busy, m_active);
      check("core_reset", core_reset, !m_active || (cyc == m_t_acc + 1));
      check("req0_ready", req0_ready, ex0);
      check("req1_ready", req1_ready, ex1);
      check("rsp_valid", rsp_valid, m_pend);
      if (m_pend) check("rsp_id", rsp_id, m_id);
      check("rsp_data", rsp_data, m_rdata);
      check("rsp_err", rsp_err, m_err);
      check("core_mode", core_mode, m_mode);
      check("core_data_in", core_data_in, m_data);
      check("core_key_in", core_key_in, m_key);
      check("job_count", job_count, m_count);
      if (busy && (req0_ready || req1_ready)) viol++;
      if (reset) begin
        m_active = 0; m_pend = 0; m_last = 1; m_mode = 0; m_id = 0; m_err = 0;
        m_data = '0; m_key = '0; m_rdata = '0; m_count = '0;
      end else if (!m_active) begin
        if (req0_valid || req1_valid) begin
          g = (req0_valid && req1_valid) ? !m_last : req1_valid;
          m_active = 1; m_t_acc = cyc; m_id = g; m_last = g;
          m_mode = g ? req1_mode : req0_mode;
          m_data = g ? req1_data : req0_data;
          m_key  = g ? req1_key  : req0_key;
          grant_log.push_back(g);
        end
      end else if (!m_pend) begin
        if (cyc >= m_t_acc + 2) begin
          if (core_done) begin
            m_pend = 1; m_rdata = gold(m_mode, m_data, m_key); m_err = 0;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (cyc - (m_t_acc + 2) == longint'(TO)) begin
            m_pend = 1; m_rdata = '0; m_err = 1;
          end
`endif
        end
      end else if (rsp_ready) begin
        r.id = m_id; r.data = m_rdata; r.err = m_err;
        rsp_log.push_back(r);
        m_pend = 0; m_active = 0; m_count = m_count + 16'd1;
      end
    end
    cyc++;
  end

  task automatic wait_rsp(input string name, output time t);
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        t = $time;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL %s: no rsp_valid within 400 cycles, expected one", name);
  endtask

  task automatic wait_run(input string name, output time t);
    t = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && core_reset === 1'b0) begin
        t = $time;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL %s: RUN not entered within 50 cycles", name);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && q0.size() == 0 && q1.size() == 0) return;
    end
    n_tests++; n_fail++;
    $display("FAIL %s: still busy after 2000 cycles, expected idle", name);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req0_ready"}, req0_ready, 1'b0);
    check({tag, "_req1_ready"}, req1_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_id"}, rsp_id, 1'b0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_core_mode"}, core_mode, 1'b0);
    check({tag, "_core_data_in"}, core_data_in, '0);
    check({tag, "_core_key_in"}, core_key_in, '0);
    check({tag, "_job_count"}, job_count, 16'd0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1;
    logic [15:0] jc0;
    int unstable, seen;
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 0; req0_mode = 0; req0_data = '0; req0_key = '0;
    req1_valid = 0; req1_mode = 0; req1_data = '0; req1_key = '0;
    @(posedge clk); #1; started = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1; reset = 1'b0;

    // Encrypt on requester 0, with end-to-end latency pinned.
    q0.push_back('{1'b0, P1, K1});
    t0 = 0;
    for (int i = 0; i < 20 && t0 == 0; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) t0 = $time;
    end
    wait_rsp("enc", t1);
    check("enc_latency", (t1 - t0) / 10, LAT + 3);
    check("enc_id", rsp_id, 1'b0);
    check("enc_data", rsp_data, C1);
    check("enc_err", rsp_err, 1'b0);
    @(negedge clk);
    check("enc_job_count", job_count, 16'd1);
    wait_idle("enc_idle");

    // Decrypt on requester 1.
    q1.push_back('{1'b1, C1, K1});
    wait_rsp("dec", t1);
    check("dec_id", rsp_id, 1'b1);
    check("dec_data", rsp_data, P1);
    wait_idle("dec_idle");

    // Fairness: both requesters continuously valid.
    rsp_log.delete(); grant_log.delete();
    q0.push_back('{1'b0, P1, K1}); q0.push_back('{1'b1, C2, K2});
    q1.push_back('{1'b1, C1, K1}); q1.push_back('{1'b0, P2, K2});
    wait_idle("fair_idle");
    check("fair_grants", grant_log.size(), 4);
    check("fair_rsps", rsp_log.size(), 4);
    if (grant_log.size() == 4 && rsp_log.size() == 4) begin
      check("fair_g0", grant_log[0], 1'b0); check("fair_g1", grant_log[1], 1'b1);
      check("fair_g2", grant_log[2], 1'b0); check("fair_g3", grant_log[3], 1'b1);
      check("fair_r0", {rsp_log[0].id, rsp_log[0].data}, {1'b0, C1});
      check("fair_r1", {rsp_log[1].id, rsp_log[1].data}, {1'b1, P1});
      check("fair_r2", {rsp_log[2].id, rsp_log[2].data}, {1'b0, P2});
      check("fair_r3", {rsp_log[3].id, rsp_log[3].data}, {1'b1, C2});
    end

    // Backpressure: hold the response for 20 cycles while requester 1 waits.
    @(posedge clk); #1; rsp_ready = 1'b0;
    jc0 = job_count;
    q0.push_back('{1'b0, P2, K2}); q1.push_back('{1'b1, C1, K1});
    wait_rsp("bp", t1);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== C2 || core_reset !== 1'b0 ||
          req1_ready !== 1'b0 || job_count !== jc0) unstable++;
    end
    check("bp_stable", unstable, 0);
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_job_count", job_count, jc0 + 16'd1);
    wait_rsp("bp_next", t1);
    check("bp_next_id", rsp_id, 1'b1);
    check("bp_next_data", rsp_data, P1);
    wait_idle("bp_idle");

`ifdef AES_ARB_TIMEOUT_EN
    // Timeout with a core whose done never rises, then a real job.
    @(posedge clk); #1; core_stuck = 1'b1;
    q0.push_back('{1'b0, P1, K1});
    wait_run("to_run", t0);
    wait_rsp("to", t1);
    check("to_latency", (t1 - t0) / 10, TO + 1);
    check("to_err", rsp_err, 1'b1);
    check("to_data", rsp_data, '0);
    @(posedge clk); #1; core_stuck = 1'b0;
    wait_idle("to_idle");
    q1.push_back('{1'b0, P2, K2});
    wait_rsp("to_after", t1);
    check("to_after_data", rsp_data, C2);
    check("to_after_err", rsp_err, 1'b0);
    wait_idle("to_after_idle");
`endif

    // Reset 10 cycles into RUN discards the job.
    q0.push_back('{1'b0, P2, K2});
    wait_run("mid_run", t0);
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    q0.push_back('{1'b0, P1, K1});
    wait_rsp("fresh", t1);
    check("fresh_id", rsp_id, 1'b0);
    check("fresh_data", rsp_data, C1);
    wait_idle("fresh_idle");

    check("no_ready_while_busy", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_arbiter.md
# aes_arbiter

Shares a single AES-128 core between two requesters and sequences each job through it. Grants one request at a time using round-robin arbitration, and latches that request's mode, data and key. Pulses the core's reset to launch the job, waits for the core's done flag, and returns the result on a valid/ready response channel tagged with the requester id. Sits between the host/UART command logic and the AES core, and owns the core's `reset`, `mode`, `data_in` and `key_in` pins.

## Interface
- `WIDTH`, 128: data/key width.
- `TIMEOUT`, 255: maximum RUN cycles before a job is aborted (used only with `AES_ARB_TIMEOUT_EN`); legal range 64..65535.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 has a job.
- `req0_ready` out 1: requester 0 job accepted this cycle when also valid.
- `req0_mode` in 1: 0 = encrypt, 1 = decrypt.
- `req0_data` in WIDTH: plaintext or ciphertext.
- `req0_key` in WIDTH: cipher key.
- `req1_valid`, `req1_ready`, `req1_mode`, `req1_data`, `req1_key`: same as requester 0, for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out WIDTH: result block.
- `rsp_err` out 1: job aborted by timeout.
- `core_reset` out 1: drives the core's `reset`.
- `core_mode` out 1: drives the core's `mode`.
- `core_data_in` out WIDTH: drives the core's `data_in`.
- `core_key_in` out WIDTH: drives the core's `key_in`.
- `core_data_out` in WIDTH: from the core.
- `core_done` in 1: the core's `aes_done`, level, held until the next core reset.
- `busy` out 1: high in every state except IDLE.
- `job_count` out 16: number of completed responses (handshakes); wraps 0xFFFF -> 0.

## Operation
- **States:** IDLE, LAUNCH, RUN, RESP.
- **IDLE:**
  - `core_reset` = 1, which parks the core.
  - The grant goes to the single valid requester. If both are valid, it goes to the requester not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = 1 only for the granted requester; it is combinational from the valids and `last_grant`.
  - On handshake: latch mode, data, key and id into the operand registers, update `last_grant`, and go to LAUNCH.
- **LAUNCH:** one cycle with `core_reset` = 1 and the new operands on the core pins. The core samples the key here. Go to RUN.
- **RUN:**
  - `core_reset` = 0; the operands are held stable for the whole job.
  - `core_done` sampled 1: capture `core_data_out` into `rsp_data`, set `rsp_err` = 0, go to RESP.
- **RESP:**
  - `rsp_valid` = 1; `rsp_id`, `rsp_data` and `rsp_err` are held stable while `rsp_ready` = 0.
  - On handshake: increment `job_count` and go to IDLE. `core_reset` returns to 1.
- **Core pins:** `core_mode`, `core_data_in` and `core_key_in` always reflect the operand registers, which are zeroed by reset.
- **One job in flight:** no request is accepted outside IDLE, and all `reqN_ready` are 0 there.
- **Reset mid-operation:** any state returns to IDLE; the in-flight job and the pending response are discarded without a response.

## Timing
- **Reset values:**
  - `req0_ready`, `req1_ready`, `rsp_valid`, `rsp_id`, `rsp_err`, `busy` = 0.
  - `rsp_data`, `core_mode`, `core_data_in`, `core_key_in` = 0.
  - `job_count` = 0.
  - `core_reset` = 1.
- **Request accepted at cycle T:** LAUNCH at T+1, RUN from T+2.
- **`core_done` sampled high at cycle D:** `rsp_valid` rises at D+1.
- **Response handshake at cycle R:** IDLE at R+1, and a new request can be accepted at R+1.
- **Minimum IDLE-to-IDLE job:** 4 cycles plus the core's compute time.
- **Requests raised while busy:** they wait with ready = 0. A requester must hold valid and its operands until it sees ready.
- **Stale `core_done`:** it is ignored in LAUNCH. The core clears it during reset, so RUN never sees a stale done.

## Configuration
- **Macro:** `AES_ARB_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit cycle counter is cleared on entry to RUN and increments each RUN cycle.
  - If it reaches `TIMEOUT` with `core_done` = 0, go to RESP with `rsp_err` = 1 and `rsp_data` = 0.
  - `core_done` and the timeout in the same cycle: done wins.
- **Undefined:** no counter; RUN waits indefinitely and `rsp_err` is tied to 0.

## Test plan
- **Encrypt:** req0 with mode = 0, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> one response with `rsp_id` = 0, `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `rsp_err` = 0, `job_count` = 1.
- **Decrypt:** req1 with mode = 1, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a -> `rsp_id` = 1, `rsp_data` = 00112233445566778899aabbccddeeff.
- **Fairness:** both requesters valid continuously with distinct jobs for 4 jobs -> grant order 0, 1, 0, 1; each `rsp_id` matches its FIPS-197 result; `reqN_ready` is never 1 while `busy`.
- **Backpressure:** hold `rsp_ready` = 0 for 20 cycles after `rsp_valid` -> outputs stable, no new request accepted, `core_reset` stays 0 until the handshake, `job_count` increments once.
- **Timeout** (`AES_ARB_TIMEOUT_EN`, `TIMEOUT` = 64, core model with `core_done` stuck 0) -> `rsp_valid` appears 65 cycles after RUN entry with `rsp_err` = 1 and `rsp_data` = 0. A following real job completes correctly.
- **Reset mid-RUN:** assert `reset` 10 cycles into RUN -> next cycle all outputs at their reset values and no response. A fresh FIPS-197 encrypt afterwards gives 69c4e0d86a7b0430d8cdb78070b4c55a.
